// File: rtl/lane_fifo.sv
// lane_fifo: per-lane receive FIFO behind the layer-2 1:2 demux. Stores up to DEPTH words
// in order. A pop returns its word one cycle later on dataOut/validOut.
// Ports: clk/reset (async, active-high); dataIn/validIn push side; pop/dataOut/validOut read side;
//        count/full/empty/almostFull/almostEmpty occupancy status; overflowErr/underflowErr sticky errors.
// Optional: define LANE_FIFO_ERR_EN to build the sticky error registers; otherwise both error ports are tied to 0.
module lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic                  overflowErr,
  output logic                  underflowErr
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  push_ok, pop_ok;

  // Flags come straight from the count register, so no input reaches them combinationally.
  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almostFull  = (count_q >= CNT_AF);
  assign almostEmpty = (count_q <= CNT_AE);
  assign count       = count_q;
  assign dataOut     = data_out_q;
  assign validOut    = valid_out_q;

  always_comb begin
    pop_ok      = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    push_ok     = validIn && (!full || pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;  // DEPTH is a power of two, so this wraps naturally
    end
    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      data_out_d  = mem[rd_ptr_q];
      valid_out_d = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Storage is not reset. When full with push and pop together, wr_ptr == rd_ptr and the read
  // returns the old word, because the write only lands at the edge.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= dataIn;
    end
  end

`ifdef LANE_FIFO_ERR_EN
  logic overflow_err_q, overflow_err_d;
  logic underflow_err_q, underflow_err_d;

  always_comb begin
    overflow_err_d  = overflow_err_q  | (validIn && !push_ok);
    underflow_err_d = underflow_err_q | (pop && !pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign overflowErr  = overflow_err_q;
  assign underflowErr = underflow_err_q;
`else
  assign overflowErr  = 1'b0;
  assign underflowErr = 1'b0;
`endif

endmodule

// File: tb/tb_lane_fifo.sv
// Testbench for lane_fifo: queue-based reference model with a per-cycle compare process,
// plus directed scenarios carrying hand-computed literal expectations.
module tb_lane_fifo;

`ifdef LANE_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [7:0] dataIn;
  logic       validIn;
  logic       pop;
  logic [7:0] dataOut;
  logic       validOut;
  logic [3:0] count;
  logic       full, empty, almostFull, almostEmpty, overflowErr, underflowErr;

  lane_fifo dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .validIn(validIn), .pop(pop),
    .dataOut(dataOut), .validOut(validOut), .count(count), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty),
    .overflowErr(overflowErr), .underflowErr(underflowErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of stored words plus the expected read-port registers.
  logic [7:0] mq[$];
  logic [7:0] m_data;
  bit         m_valid, m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_data = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit pop_acc, push_acc;
      pop_acc  = pop && (mq.size() > 0);
      push_acc = validIn && ((mq.size() < DEPTH) || pop_acc);
      if (pop_acc) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (push_acc) mq.push_back(dataIn);
      if (ERR_EN && validIn && !push_acc) m_ovf = 1'b1;
      if (ERR_EN && pop && !pop_acc)      m_unf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (running) begin
      int n;
      n = mq.size();
      check("cmp_count",   32'(count),       32'(n));
      check("cmp_full",    32'(full),        32'(n == DEPTH));
      check("cmp_empty",   32'(empty),       32'(n == 0));
      check("cmp_afull",   32'(almostFull),  32'(n >= 6));
      check("cmp_aempty",  32'(almostEmpty), 32'(n <= 2));
      check("cmp_valid",   32'(validOut),    32'(m_valid));
      check("cmp_data",    32'(dataOut),     32'(m_data));
      check("cmp_ovf",     32'(overflowErr), 32'(m_ovf));
      check("cmp_unf",     32'(underflowErr),32'(m_unf));
    end
  end

  // One clock of stimulus: inputs change on the falling edge, results are sampled 1 after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic p);
    @(negedge clk);
    validIn = v; dataIn = d; pop = p;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a1_a8();
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0);
  endtask

  initial begin
    reset = 1'b1; validIn = 1'b0; dataIn = 8'h00; pop = 1'b0;
    #1;
    running = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almostEmpty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(validOut), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: fill A1..A8
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hA1 + 8'(i), 1'b0);
      check("t1_count", 32'(count), 32'(i + 1));
      check("t1_afull", 32'(almostFull), 32'(i + 1 >= 6));
      check("t1_full",  32'(full), 32'(i == 7));
      check("t1_empty", 32'(empty), 0);
    end

    // 2: drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("t2_data",   32'(dataOut), 32'(8'hA1 + 8'(i)));
      check("t2_valid",  32'(validOut), 1);
      check("t2_aempty", 32'(almostEmpty), 32'(7 - i <= 2));
    end
    check("t2_empty", 32'(empty), 1);
    step(1'b0, 8'h00, 1'b0);
    check("t2_valid_off", 32'(validOut), 0);

    // 3: push into full FIFO is dropped
    fill_a1_a8();
    step(1'b1, 8'hFF, 1'b0);
    check("t3_count", 32'(count), 8);
    check("t3_ovf", 32'(overflowErr), 32'(ERR_EN));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("t3_data", 32'(dataOut), 32'(8'hA1 + 8'(i)));
    end
    step(1'b0, 8'h00, 1'b0);
    check("t3_empty", 32'(empty), 1);

    // 4: full, simultaneous push 0x55 and pop
    fill_a1_a8();
    step(1'b1, 8'h55, 1'b1);
    check("t4_count", 32'(count), 8);
    check("t4_data", 32'(dataOut), 32'hA1);
    check("t4_valid", 32'(validOut), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("t4_data_seq", 32'(dataOut), (i == 7) ? 32'h55 : 32'(8'hA2 + 8'(i)));
    end
    step(1'b0, 8'h00, 1'b0);

    // 5: empty, pop with push 0x3C
    step(1'b1, 8'h3C, 1'b1);
    check("t5_valid", 32'(validOut), 0);
    check("t5_unf", 32'(underflowErr), 32'(ERR_EN));
    check("t5_count", 32'(count), 1);
    step(1'b0, 8'h00, 1'b1);
    check("t5_data", 32'(dataOut), 32'h3C);
    check("t5_valid2", 32'(validOut), 1);
    step(1'b0, 8'h00, 1'b0);

    // 6: 3-deep steady state across several pointer wraps
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b1);
      check("t6_data", 32'(dataOut), (i < 3) ? 32'(8'hB0 + 8'(i)) : 32'(8'hC0 + 8'(i - 3)));
      check("t6_count", 32'(count), 3);
    end
    // async reset between edges, with push/pop still driven
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_valid", 32'(validOut), 0);
    check("t6_rst_ovf", 32'(overflowErr), 0);
    check("t6_rst_unf", 32'(underflowErr), 0);
    @(negedge clk);
    validIn = 1'b0; pop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    check("t6_first_push", 32'(count), 1);
    step(1'b0, 8'h00, 1'b1);
    check("t6_first_data", 32'(dataOut), 32'h77);
    step(1'b0, 8'h00, 1'b0);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
